// File: rtl/jpeb_unified_mem.sv
// Unified 64K x 16 JPEB memory: fetch port, data port with PS/2 key mapping,
// CPU write port and a downscaled framebuffer scan-out to the VGA block.
module jpeb_unified_mem #(
  parameter logic [15:0] FB_BASE  = 16'hA000,
  parameter int          FB_W     = 160,
  parameter int          FB_H     = 120,
  parameter int          SCALE_SH = 2,
  parameter logic [15:0] PS2_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raddr0,
  output logic [15:0] rdata0,
  input  logic        ren,
  input  logic [15:0] raddr1,
  output logic [15:0] rdata1,
  input  logic        wen,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  output logic        ps2_ren,
  input  logic [15:0] ps2_data_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [11:0] pixel
);

  localparam logic [15:0] FB_W16 = 16'(FB_W);
  localparam logic [9:0]  FB_W10 = 10'(FB_W);
  localparam logic [9:0]  FB_H10 = 10'(FB_H);

  logic [15:0] mem [65536];

  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        ps2_ren_q, ps2_ren_d;
  logic [11:0] pixel_q, pixel_d;

  logic [9:0]  fx_s;
  logic [9:0]  fy_s;
  logic [15:0] fb_addr_s;
  logic        in_fb_s;
  logic        ps2_hit_s;
  logic        wr_ok_s;

  assign fx_s      = pixel_x >> SCALE_SH;
  assign fy_s      = pixel_y >> SCALE_SH;
  assign fb_addr_s = FB_BASE + ({6'd0, fy_s} * FB_W16) + {6'd0, fx_s};
  assign in_fb_s   = (fx_s < FB_W10) && (fy_s < FB_H10);
  assign ps2_hit_s = ren && (raddr1 == PS2_ADDR);
  // The key register has no backing store, so writes aimed at it are discarded.
  assign wr_ok_s   = wen && (waddr != PS2_ADDR);

  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_comb begin
    rdata0_d  = mem[raddr0];
    rdata1_d  = rdata1_q;
    ps2_ren_d = ps2_hit_s;
    pixel_d   = 12'd0;
    if (ps2_hit_s) begin
      rdata1_d = ps2_data_in;
    end else if (ren) begin
      rdata1_d = mem[raddr1];
    end else begin
      rdata1_d = rdata1_q;
    end
    if (in_fb_s) begin
      pixel_d = mem[fb_addr_s][11:0];
    end else begin
      pixel_d = 12'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q  <= 16'd0;
      rdata1_q  <= 16'd0;
      ps2_ren_q <= 1'b0;
      pixel_q   <= 12'd0;
    end else begin
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      ps2_ren_q <= ps2_ren_d;
      pixel_q   <= pixel_d;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign ps2_ren = ps2_ren_q;
  assign pixel   = pixel_q;

endmodule

// File: tb/tb_jpeb_unified_mem.sv
// Randomised bench for jpeb_unified_mem against an array-based memory model.
module tb_jpeb_unified_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] raddr0, raddr1, waddr, wdata, ps2_data_in;
  logic        ren, wen;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] rdata0, rdata1;
  logic        ps2_ren;
  logic [11:0] pixel;

  int checks = 0;
  int failures = 0;

  logic [15:0] model [65536];
  bit          known [65536];
  logic [15:0] exp_r1;
  bit          exp_r1_k;

  jpeb_unified_mem dut (
    .clk(clk), .reset(reset),
    .raddr0(raddr0), .rdata0(rdata0),
    .ren(ren), .raddr1(raddr1), .rdata1(rdata1),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .ps2_ren(ps2_ren), .ps2_data_in(ps2_data_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel(pixel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict from the model (old contents), check, then commit the write.
  task automatic cycle(input bit w, input logic [15:0] wa, input logic [15:0] wd,
                       input bit r, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [9:0] px, input logic [9:0] py, input logic [15:0] kd);
    logic [15:0] e0, fa;
    bit          e0k, eps, epk;
    logic [11:0] ep;
    int          fx, fy;
    @(negedge clk);
    wen = w; waddr = wa; wdata = wd; ren = r; raddr0 = a0; raddr1 = a1;
    pixel_x = px; pixel_y = py; ps2_data_in = kd;
    e0 = model[a0]; e0k = known[a0];
    eps = r && (a1 == 16'hFFFF);
    if (eps) begin
      exp_r1 = kd; exp_r1_k = 1'b1;
    end else if (r) begin
      exp_r1 = model[a1]; exp_r1_k = known[a1];
    end
    fx = int'(px) / 4;
    fy = int'(py) / 4;
    if (fx >= 160 || fy >= 120) begin
      ep = 12'd0; epk = 1'b1;
    end else begin
      fa = 16'(32'hA000 + fy * 160 + fx);
      ep = model[fa][11:0]; epk = known[fa];
    end
    @(posedge clk); #1;
    if (e0k) check_val("rdata0", rdata0, e0);
    if (exp_r1_k) check_val("rdata1", rdata1, exp_r1);
    check_val("ps2_ren", {15'd0, ps2_ren}, {15'd0, eps});
    if (epk) check_val("pixel", {4'd0, pixel}, {4'd0, ep});
    if (w && wa != 16'hFFFF) begin
      model[wa] = wd; known[wa] = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0100, 16'h0100, 10'd640, 10'd0, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; wen = 1'b0; ren = 1'b0; raddr0 = 16'h0; raddr1 = 16'h0;
    waddr = 16'h0; wdata = 16'h0; ps2_data_in = 16'h0; pixel_x = 10'd0; pixel_y = 10'd0;
    exp_r1 = 16'h0; exp_r1_k = 1'b1;
    #12;
    check_val("rst_rdata0", rdata0, 16'h0000);
    check_val("rst_rdata1", rdata1, 16'h0000);
    check_val("rst_ps2_ren", {15'd0, ps2_ren}, 16'h0000);
    check_val("rst_pixel", {4'd0, pixel}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Preload framebuffer rows 0..6 and a scratch region.
    for (int i = 0; i < 1120; i++)
      cycle(1'b1, 16'(32'hA000 + i), 16'($urandom), 1'b0, 16'h0, 16'h0, 10'd640, 10'd0, 16'h0);
    for (int i = 0; i < 256; i++)
      cycle(1'b1, 16'(32'h0300 + i), 16'($urandom), 1'b0, 16'h0, 16'h0, 10'd640, 10'd0, 16'h0);

    // Write then read on both ports.
    cycle(1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0, 16'h0, 10'd640, 10'd0, 16'h0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 16'h0100, 10'd640, 10'd0, 16'h0);
    check_val("t1_rdata0", rdata0, 16'hBEEF);
    check_val("t1_rdata1", rdata1, 16'hBEEF);

    // Read-during-write returns old data.
    cycle(1'b1, 16'h0200, 16'h1111, 1'b0, 16'h0, 16'h0, 10'd640, 10'd0, 16'h0);
    cycle(1'b1, 16'h0200, 16'h2222, 1'b1, 16'h0200, 16'h0200, 10'd640, 10'd0, 16'h0);
    check_val("t2_old", rdata1, 16'h1111);
    check_val("t2_old_p0", rdata0, 16'h1111);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0200, 16'h0200, 10'd640, 10'd0, 16'h0);
    check_val("t2_new", rdata1, 16'h2222);

    // PS/2 read pulse, then ren=0 holds.
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 16'hFFFF, 10'd640, 10'd0, 16'h001C);
    check_val("t3_key", rdata1, 16'h001C);
    check_val("t3_pulse", {15'd0, ps2_ren}, 16'h0001);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0100, 16'hFFFF, 10'd640, 10'd0, 16'h0055);
    check_val("t3_hold", rdata1, 16'h001C);
    check_val("t3_nopulse", {15'd0, ps2_ren}, 16'h0000);

    // Framebuffer pixel at (9,5) -> fx=2, fy=1.
    cycle(1'b1, 16'hA0A2, 16'h0F0A, 1'b0, 16'h0, 16'h0, 10'd640, 10'd0, 16'h0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0100, 16'h0, 10'd9, 10'd5, 16'h0);
    check_val("t4_pixel", {4'd0, pixel}, 16'h0F0A);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0100, 16'h0, 10'd640, 10'd5, 16'h0);
    check_val("t4_xedge", {4'd0, pixel}, 16'h0000);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0100, 16'h0, 10'd9, 10'd480, 16'h0);
    check_val("t4_yedge", {4'd0, pixel}, 16'h0000);

    // Writes to the key address are dropped; back-to-back key reads pulse twice.
    cycle(1'b1, 16'hFFFF, 16'h1234, 1'b1, 16'h0100, 16'hFFFF, 10'd9, 10'd5, 16'h00AB);
    check_val("t6_key", rdata1, 16'h00AB);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 16'hFFFF, 10'd9, 10'd5, 16'h00CD);
    check_val("t6_key2", rdata1, 16'h00CD);
    check_val("t6_pulse2", {15'd0, ps2_ren}, 16'h0001);
    check_val("t6_ram", rdata0, 16'hBEEF);

    // Asynchronous reset with nonzero outputs.
    #2 reset = 1'b1;
    #1;
    check_val("t5_rdata0", rdata0, 16'h0000);
    check_val("t5_rdata1", rdata1, 16'h0000);
    check_val("t5_ps2_ren", {15'd0, ps2_ren}, 16'h0000);
    check_val("t5_pixel", {4'd0, pixel}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check_val("t5_held", rdata0, 16'h0000);
    reset = 1'b0;
    exp_r1 = 16'h0000; exp_r1_k = 1'b1;
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 16'h0100, 10'd640, 10'd0, 16'h0);
    check_val("t5_after", rdata1, 16'hBEEF);
    idle();

    // Randomised traffic over the preloaded regions.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] wa, a0, a1;
      logic [9:0]  px, py;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      wa = 16'(32'h0300 + $urandom_range(0, 255));
      else if (sel < 8) wa = 16'(32'hA000 + $urandom_range(0, 1119));
      else              wa = 16'hFFFF;
      a0 = ($urandom_range(0, 1) == 0) ? 16'(32'h0300 + $urandom_range(0, 255))
                                       : 16'(32'hA000 + $urandom_range(0, 1119));
      sel = $urandom_range(0, 3);
      if (sel == 0)      a1 = 16'hFFFF;
      else if (sel == 1) a1 = 16'(32'hA000 + $urandom_range(0, 1119));
      else               a1 = 16'(32'h0300 + $urandom_range(0, 255));
      px = 10'($urandom_range(0, 700));
      py = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 27));
      cycle(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)),
            a0, a1, px, py, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
